packet_scheduler: RTL and testbench
===================================

# packet_scheduler

Hardware sequencer feeding the per-channel word-offer interface (`out_data`/`out_end`/`out_nempty`/`out_pop`) without CPU involvement. It accepts 64-bit packet words from an upstream FIFO and assigns each whole packet to one enabled output channel, round-robin. It offers the packet word by word on that channel and waits for the channel's pop. Stalled channels are recovered by a per-word timeout that drops the rest of the packet.

## Interface
Parameters:
- `CHANNELS`, 4: number of output channels (1..16).
- `TIMEOUT_BITS`, 16: width of the per-word pop-wait timer.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `resetn`  in  1  synchronous active-low reset.
- `in_valid`  in  1  upstream word available.
- `in_data`  in  64  upstream word.
- `in_end`  in  1  word is last of packet.
- `in_ready`  out  1  word accepted on posedge when `in_valid && in_ready`; combinational from state.
- `ch_enable`  in  CHANNELS  channels eligible for new packets.
- `out_pop`  in  CHANNELS  channel consumed offered word.
- `out_nempty`  out  CHANNELS  one-hot, or zero, word-offered flag.
- `out_data`  out  64  offered word.
- `out_end`  out  1  offered word is last of packet.
- `busy`  out  1  packet in progress (state ≠ IDLE).
- `timeout_count`  out  16  saturating count of timed-out words.

## Operation
- The state machine has four states: IDLE, OFFER, NEXT and DROP.
- In IDLE:
  - `in_ready = |ch_enable`.
  - On accept, grant the first enabled channel strictly after `last_grant`, wrapping. Latch data/end, set `out_nempty` one-hot to the grant, clear the timer, and go to OFFER.
- In OFFER:
  - `in_ready = 0`, and the timer increments each cycle.
  - If `out_pop[grant]` is high, clear `out_nempty`. Then go to IDLE if `out_end` (with `last_grant <= grant`); otherwise go to NEXT.
  - Pops on non-granted channels are ignored.
  - If the timer reaches all-ones without a pop:
    - clear `out_nempty` and increment `timeout_count`, saturating at 0xFFFF;
    - go to IDLE (with `last_grant <= grant`) if `out_end`, otherwise go to DROP.
  - Pop and timer expiry in the same cycle count as a pop.
- In NEXT:
  - `in_ready = 1`. On accept, latch data/end, set `out_nempty` to the same grant, clear the timer, and go to OFFER.
- In DROP:
  - `in_ready = 1`. Accepted words are discarded.
  - The word with `in_end` returns the block to IDLE and sets `last_grant <= grant`.
- `ch_enable` is sampled only in IDLE. Disabling the granted channel mid-packet does not abort the packet.
- `out_data`/`out_end` hold their last value while `out_nempty` is zero.
- Reset:
  - All outputs and `timeout_count` go to 0, and the state goes to IDLE.
  - `last_grant` resets to `CHANNELS-1`, so the first grant is channel 0.
  - `in_ready` is 0 while `resetn` is low.
  - A reset mid-packet abandons the packet. No partial state survives.

## Timing
- Accept at edge t → `out_nempty[g]` is high from t+1.
- Pop sampled at edge t (`out_nempty` high) → `out_nempty` is low at t+1.
- Within a packet, `in_ready` rises at t+1 (NEXT), the next word can be accepted at edge t+1, and it is offered at t+2. Sustained throughput is one word per 2 cycles.
- A pop in the first cycle `out_nempty` is high is valid.
- A timeout fires on the 2^TIMEOUT_BITS−1-th cycle in OFFER without a pop.
- After the end word's pop, the next packet can be accepted on the following edge.

## Structure
- Shared package (`utils.v` defines): the state encoding constants, and `TIMEOUT_BITS` default.
- One sub-module, `rr_pick`:
  - combinational; inputs `ch_enable` and `last_grant`;
  - outputs the one-hot grant plus its index, with wrap-around;
  - reusable by other arbiters.

## Test plan
- Round-robin: CHANNELS=4, all enabled, four 1-word packets, each popped 2 cycles after offer → grants 0,1,2,3, and the 5th packet goes to 0.
- Skipping: `ch_enable=4'b1010` after reset, two packets → grants 1 then 3. With `ch_enable=0` and `in_valid` high, `in_ready` stays 0 for 10 cycles.
- Multi-word: 3-word packet D0..D2 with immediate pops → `out_nempty` pulses on the same channel, `out_end` only with D2, and words are offered at cycles t+1, t+3, t+5.
- Timeout/drop: TIMEOUT_BITS=4, no pop on word 0 of a 3-word packet:
  - `out_nempty` clears after 15 cycles and `timeout_count=1`;
  - words 1–2 are accepted and discarded;
  - the next packet goes to the next channel.
- Same-cycle events: the pop arrives on the expiry cycle → no count increment. A pop on a non-granted channel has no effect.
- Reset mid-packet: `resetn` low for 1 cycle during OFFER of word 1 → all outputs are 0 next cycle, and the next packet is granted channel 0.

Source files
------------

// File: rtl/packet_scheduler_pkg.sv
// Shared types, widths and helpers for the packet scheduler.
package packet_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_NEXT  = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  localparam int DATA_W            = 64;
  localparam int TIMEOUT_BITS_DFLT = 16;
  localparam int TCOUNT_W          = 16;

  function automatic logic [TCOUNT_W-1:0] sat_inc(input logic [TCOUNT_W-1:0] v);
    return (&v) ? v : v + TCOUNT_W'(1);
  endfunction

endpackage

// File: rtl/packet_scheduler_if.sv
// Upstream word stream plus per-channel word-offer signals of the packet scheduler.
interface packet_scheduler_if #(
  parameter int CHANNELS = 4
);
  logic                                   in_valid;
  logic [packet_scheduler_pkg::DATA_W-1:0] in_data;
  logic                                   in_end;
  logic                                   in_ready;
  logic [CHANNELS-1:0]                    ch_enable;
  logic [CHANNELS-1:0]                    out_pop;
  logic [CHANNELS-1:0]                    out_nempty;
  logic [packet_scheduler_pkg::DATA_W-1:0] out_data;
  logic                                   out_end;

  modport master (
    output in_valid, in_data, in_end, ch_enable, out_pop,
    input  in_ready, out_nempty, out_data, out_end
  );

  modport slave (
    input  in_valid, in_data, in_end, ch_enable, out_pop,
    output in_ready, out_nempty, out_data, out_end
  );
endinterface

// File: rtl/packet_scheduler_rr_pick.sv
// Combinational round-robin picker: first enabled channel strictly after last_grant, wrapping.
module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] ch_enable,
  input  logic [CW-1:0]       last_grant,
  output logic [CHANNELS-1:0] grant_oh,
  output logic [CW-1:0]       grant_idx,
  output logic                grant_valid
);

  logic [CW-1:0] idx;

  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    // Offset CHANNELS lands back on last_grant itself, so a lone enabled channel is re-granted.
    for (int off = 1; off <= CHANNELS; off++) begin
      idx = CW'((int'(last_grant) + off) % CHANNELS);
      if (!grant_valid && ch_enable[idx]) begin
        grant_valid    = 1'b1;
        grant_idx      = idx;
        grant_oh[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_scheduler.sv
// Assigns whole packets round-robin to enabled channels and offers them word by word,
// dropping the remainder of a packet whose channel stalls past the pop-wait timeout.
//
// state    | meaning
// ST_IDLE  | no packet; first word accepted if any channel enabled
// ST_OFFER | word offered on granted channel, waiting for pop or timeout
// ST_NEXT  | word popped, waiting for next word of the same packet
// ST_DROP  | channel timed out; swallowing words up to the packet end
module packet_scheduler
  import packet_scheduler_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DFLT
) (
  input  logic                clk,
  input  logic                resetn,
  packet_scheduler_if.slave   bus,
  output logic                busy,
  output logic [TCOUNT_W-1:0] timeout_count
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [TIMEOUT_BITS-1:0] TIMER_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  state_e                  state_q, state_d;
  logic [CW-1:0]           grant_q, grant_d;
  logic [CW-1:0]           last_grant_q, last_grant_d;
  logic [CHANNELS-1:0]     nempty_q, nempty_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    end_q, end_d;
  logic [TIMEOUT_BITS-1:0] timer_q, timer_d;
  logic [TCOUNT_W-1:0]     tcount_q, tcount_d;

  logic                    in_ready;
  logic                    accept;
  logic                    pop_hit;
  logic                    expire;
  logic [CHANNELS-1:0]     pick_oh;
  logic [CW-1:0]           pick_idx;
  logic                    pick_valid;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .CW       (CW)
  ) u_rr_pick (
    .ch_enable   (bus.ch_enable),
    .last_grant  (last_grant_q),
    .grant_oh    (pick_oh),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  always_comb begin
    in_ready = 1'b0;
    if (resetn) begin
      case (state_q)
        ST_IDLE:  in_ready = pick_valid;
        ST_NEXT:  in_ready = 1'b1;
        ST_DROP:  in_ready = 1'b1;
        default:  in_ready = 1'b0;
      endcase
    end
  end

  assign accept  = bus.in_valid && in_ready;
  assign pop_hit = bus.out_pop[grant_q];
  // Timer value is compared before the increment so expiry lands on cycle 2^N-1 of the offer.
  assign expire  = (timer_q == TIMER_LAST);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    nempty_d     = nempty_q;
    data_d       = data_q;
    end_d        = end_q;
    timer_d      = timer_q;
    tcount_d     = tcount_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          grant_d  = pick_idx;
          nempty_d = pick_oh;
          data_d   = bus.in_data;
          end_d    = bus.in_end;
          timer_d  = '0;
          state_d  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        timer_d = timer_q + TIMEOUT_BITS'(1);
        if (pop_hit) begin
          nempty_d = '0;
          if (end_q) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (expire) begin
          nempty_d = '0;
          tcount_d = sat_inc(tcount_q);
          if (end_q) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_NEXT: begin
        if (accept) begin
          nempty_d          = '0;
          nempty_d[grant_q] = 1'b1;
          data_d            = bus.in_data;
          end_d             = bus.in_end;
          timer_d           = '0;
          state_d           = ST_OFFER;
        end
      end
      ST_DROP: begin
        if (accept && bus.in_end) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(CHANNELS - 1);
      nempty_q     <= '0;
      data_q       <= '0;
      end_q        <= 1'b0;
      timer_q      <= '0;
      tcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      nempty_q     <= nempty_d;
      data_q       <= data_d;
      end_q        <= end_d;
      timer_q      <= timer_d;
      tcount_q     <= tcount_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_nempty = nempty_q;
  assign bus.out_data   = data_q;
  assign bus.out_end    = end_q;
  assign busy           = (state_q != ST_IDLE);
  assign timeout_count  = tcount_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Self-checking bench for packet_scheduler: round-robin vector table, scoreboard of popped
// words, and hand sequences for multi-word, timeout/drop, same-cycle pop and mid-packet reset.
module tb_packet_scheduler;

  typedef struct {
    bit          rst;
    logic [3:0]  en;
    logic [63:0] data;
    int          dly;
    int          ch;
  } vec_t;

  typedef struct {
    int          ch;
    logic [63:0] data;
    logic        last;
  } sb_t;

  logic        clk;
  logic        resetn;
  logic        busy;
  logic [15:0] timeout_count;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;
  int          pop_cnt = 0;
  int          pop_delay = 1;
  bit          auto_en = 1'b1;
  logic [3:0]  auto_pop = 4'b0;
  logic [3:0]  man_pop  = 4'b0;
  logic [3:0]  prev_nempty = 4'b0;
  sb_t         sb[$];
  int          offer_cyc[$];
  vec_t        vec[13];

  packet_scheduler_if #(.CHANNELS(4)) bus ();

  packet_scheduler #(
    .CHANNELS     (4),
    .TIMEOUT_BITS (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  assign bus.out_pop = auto_en ? auto_pop : man_pop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Pop driver and scoreboard: pops decided at negedge are sampled by the DUT at the next posedge.
  initial begin
    logic [3:0] eff;
    sb_t        e;
    forever begin
      @(negedge clk);
      if (bus.out_nempty == 4'b0) begin
        pop_cnt  = 0;
        auto_pop = 4'b0;
      end else begin
        if (prev_nempty == 4'b0) offer_cyc.push_back(cyc);
        pop_cnt++;
        auto_pop = (pop_cnt >= pop_delay) ? bus.out_nempty : 4'b0;
      end
      prev_nempty = bus.out_nempty;
      eff = auto_en ? auto_pop : man_pop;
      if ((eff & bus.out_nempty) != 4'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("pop_onehot", 64'($onehot(bus.out_nempty)), 64'(1));
          chk("pop_chan", 64'(oh_idx(bus.out_nempty)), 64'(e.ch));
          chk("pop_data", bus.out_data, e.data);
          chk("pop_end", 64'(bus.out_end), 64'(e.last));
        end
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_end   = e;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    man_pop       = 4'b0;
    bus.ch_enable = 4'hF;
    resetn        = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("rst_nempty", 64'(bus.out_nempty), 64'(0));
    chk("rst_data", bus.out_data, 64'(0));
    chk("rst_end", 64'(bus.out_end), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tcount", 64'(timeout_count), 64'(0));
    sb.delete();
  endtask

  initial begin
    int n;
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_end    = 1'b0;
    bus.ch_enable = 4'h0;

    vec[0]  = '{1'b1, 4'hF, 64'h1111_0000_0000_0001, 2, 0};
    vec[1]  = '{1'b0, 4'hF, 64'h1111_0000_0000_0002, 2, 1};
    vec[2]  = '{1'b0, 4'hF, 64'h1111_0000_0000_0003, 2, 2};
    vec[3]  = '{1'b0, 4'hF, 64'h1111_0000_0000_0004, 2, 3};
    vec[4]  = '{1'b0, 4'hF, 64'h1111_0000_0000_0005, 2, 0};
    vec[5]  = '{1'b1, 4'hA, 64'h2222_0000_0000_0006, 1, 1};
    vec[6]  = '{1'b0, 4'hA, 64'h2222_0000_0000_0007, 3, 3};
    vec[7]  = '{1'b0, 4'hA, 64'h2222_0000_0000_0008, 1, 1};
    vec[8]  = '{1'b0, 4'h4, 64'h3333_0000_0000_0009, 1, 2};
    vec[9]  = '{1'b0, 4'h9, 64'h3333_0000_0000_000A, 2, 3};
    vec[10] = '{1'b0, 4'h9, 64'h3333_0000_0000_000B, 1, 0};
    vec[11] = '{1'b0, 4'h1, 64'h4444_0000_0000_000C, 1, 0};
    vec[12] = '{1'b0, 4'h8, 64'h4444_0000_0000_000D, 1, 3};

    for (int i = 0; i < 13; i++) begin
      if (vec[i].rst) do_reset();
      bus.ch_enable = vec[i].en;
      pop_delay     = vec[i].dly;
      auto_en       = 1'b1;
      sb.push_back('{ch: vec[i].ch, data: vec[i].data, last: 1'b1});
      send_word(vec[i].data, 1'b1);
      drain();
    end

    // No enabled channel: upstream word must never be taken.
    bus.ch_enable = 4'h0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hBAD0_BAD0_BAD0_BAD0;
    bus.in_end    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dis_in_ready", 64'(bus.in_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    chk("dis_busy", 64'(busy), 64'(0));
    bus.in_valid = 1'b0;

    // Multi-word packet, immediate pops, channel disabled after the first word.
    do_reset();
    pop_delay = 1;
    auto_en   = 1'b1;
    offer_cyc.delete();
    sb.push_back('{ch: 0, data: 64'hD0D0_0000_0000_0000, last: 1'b0});
    sb.push_back('{ch: 0, data: 64'hD1D1_0000_0000_0001, last: 1'b0});
    sb.push_back('{ch: 0, data: 64'hD2D2_0000_0000_0002, last: 1'b1});
    send_word(64'hD0D0_0000_0000_0000, 1'b0);
    bus.ch_enable = 4'h0;
    send_word(64'hD1D1_0000_0000_0001, 1'b0);
    send_word(64'hD2D2_0000_0000_0002, 1'b1);
    drain();
    chk("mw_offers", 64'(offer_cyc.size()), 64'(3));
    if (offer_cyc.size() == 3) begin
      chk("mw_gap1", 64'(offer_cyc[1] - offer_cyc[0]), 64'(2));
      chk("mw_gap2", 64'(offer_cyc[2] - offer_cyc[1]), 64'(2));
    end
    chk("mw_busy", 64'(busy), 64'(0));
    bus.ch_enable = 4'hF;

    // Timeout on word 0 of a 3-word packet, remaining words dropped.
    do_reset();
    auto_en = 1'b0;
    send_word(64'hE0E0_0000_0000_0000, 1'b0);
    n = 0;
    while (bus.out_nempty != 4'b0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("to_len", 64'(n), 64'(15));
    chk("to_count1", 64'(timeout_count), 64'(1));
    chk("to_busy_drop", 64'(busy), 64'(1));
    send_word(64'hE1E1_0000_0000_0001, 1'b0);
    chk("drop_nempty1", 64'(bus.out_nempty), 64'(0));
    send_word(64'hE2E2_0000_0000_0002, 1'b1);
    chk("drop_nempty2", 64'(bus.out_nempty), 64'(0));
    chk("drop_busy", 64'(busy), 64'(0));
    auto_en   = 1'b1;
    pop_delay = 1;
    sb.push_back('{ch: 1, data: 64'hF1F1_0000_0000_0001, last: 1'b1});
    send_word(64'hF1F1_0000_0000_0001, 1'b1);
    drain();

    // Timeout on a single-word packet returns straight to idle.
    auto_en = 1'b0;
    send_word(64'hF2F2_0000_0000_0002, 1'b1);
    chk("to2_chan", 64'(bus.out_nempty), 64'(4'b0100));
    n = 0;
    while (bus.out_nempty != 4'b0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("to2_len", 64'(n), 64'(15));
    chk("to2_count", 64'(timeout_count), 64'(2));
    chk("to2_busy", 64'(busy), 64'(0));
    auto_en = 1'b1;
    sb.push_back('{ch: 3, data: 64'hF3F3_0000_0000_0003, last: 1'b1});
    send_word(64'hF3F3_0000_0000_0003, 1'b1);
    drain();

    // Foreign-channel pops are ignored; a pop on the expiry cycle wins over the timeout.
    do_reset();
    auto_en = 1'b0;
    send_word(64'h5A5A_0000_0000_0000, 1'b1);
    sb.push_back('{ch: 0, data: 64'h5A5A_0000_0000_0000, last: 1'b1});
    man_pop = 4'b1110;
    repeat (5) @(posedge clk);
    #1;
    chk("foreign_pop_nempty", 64'(bus.out_nempty), 64'(4'b0001));
    man_pop = 4'b0000;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_expiry_nempty", 64'(bus.out_nempty), 64'(4'b0001));
    man_pop = 4'b0001;
    @(posedge clk);
    #1;
    man_pop = 4'b0000;
    chk("same_cycle_nempty", 64'(bus.out_nempty), 64'(0));
    chk("same_cycle_tcount", 64'(timeout_count), 64'(0));
    chk("same_cycle_busy", 64'(busy), 64'(0));
    chk("same_cycle_sb", 64'(sb.size()), 64'(0));
    auto_en = 1'b1;

    // Reset during the offer of word 1 abandons the packet and restarts arbitration.
    do_reset();
    auto_en   = 1'b1;
    pop_delay = 1;
    sb.push_back('{ch: 0, data: 64'h7070_0000_0000_0000, last: 1'b1});
    send_word(64'h7070_0000_0000_0000, 1'b1);
    drain();
    auto_en = 1'b0;
    send_word(64'h7171_0000_0000_0000, 1'b0);
    sb.push_back('{ch: 1, data: 64'h7171_0000_0000_0000, last: 1'b0});
    man_pop = 4'b0010;
    @(posedge clk);
    #1;
    man_pop = 4'b0000;
    send_word(64'h7171_0000_0000_0001, 1'b0);
    chk("mid_offer_w1", 64'(bus.out_nempty), 64'(4'b0010));
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_nempty", 64'(bus.out_nempty), 64'(0));
    chk("mid_rst_data", bus.out_data, 64'(0));
    chk("mid_rst_end", 64'(bus.out_end), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    resetn  = 1'b1;
    auto_en = 1'b1;
    sb.push_back('{ch: 0, data: 64'h7272_0000_0000_0000, last: 1'b1});
    send_word(64'h7272_0000_0000_0000, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
